word_serializer: RTL and testbench

//   Downstream consumer of the DATA_WIDTH register stage: takes one full word per

---
 rtl/word_serializer_pkg.sv | 19 +
 rtl/word_serializer.sv | 113 +++++++++++
 tb/tb_word_serializer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer / deserializer pair:
// FSM state encodings and the slice-count / counter-width derivation.
package word_serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    function automatic int calc_num_slices(input int data_width, input int out_width);
        calc_num_slices = data_width / out_width;
    endfunction

    // Never returns zero so a counter declared from it is always a legal vector.
    function automatic int calc_cnt_w(input int num_slices);
        calc_cnt_w = (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits one DATA_WIDTH word per input handshake into NUM_SLICES OUT_WIDTH
// slices under valid/ready, reloading on the last slice so words stream gap-free.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [OUT_WIDTH-1:0]  data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o
);

    localparam int NUM_SLICES = calc_num_slices(DATA_WIDTH, OUT_WIDTH);
    localparam int CNT_W      = calc_cnt_w(NUM_SLICES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    if ((NUM_SLICES < 2) || ((DATA_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_params
        $error("word_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH giving at least 2 slices");
    end

    ser_state_e            state_r;
    ser_state_e            state_nxt_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shift_nxt_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic                  in_hs_s;
    logic                  out_hs_s;

    // The output end of the shift register depends on slice order; shifting
    // always moves the next slice into that end and zero-fills behind it.
    if (MSB_FIRST) begin : g_msb_first
        assign shifted_s = {shift_r[DATA_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
        assign data_o    = shift_r[DATA_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb_first
        assign shifted_s = {{OUT_WIDTH{1'b0}}, shift_r[DATA_WIDTH-1:OUT_WIDTH]};
        assign data_o    = shift_r[OUT_WIDTH-1:0];
    end

    assign valid_o = (state_r == ST_SHIFT);
    assign busy_o  = valid_o;
    assign last_o  = (state_r == ST_SHIFT) && (cnt_r == LAST_CNT);

    // ready_i feeds ready_o combinationally so a new word lands on the final slice's edge.
    assign ready_o  = (state_r == ST_IDLE) || (last_o && ready_i);
    assign in_hs_s  = valid_i && ready_o;
    assign out_hs_s = valid_o && ready_i;

    // Next-state, shift-register and slice-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (in_hs_s) begin
                    shift_nxt_s = data_i;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    shift_nxt_s = '0;
                    cnt_nxt_s   = '0;
                end
            end
            ST_SHIFT: begin
                if (out_hs_s) begin
                    if (cnt_r != LAST_CNT) begin
                        shift_nxt_s = shifted_s;
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                    end else if (in_hs_s) begin
                        shift_nxt_s = data_i;
                        cnt_nxt_s   = '0;
                    end else begin
                        shift_nxt_s = '0;
                        cnt_nxt_s   = '0;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                shift_nxt_s = '0;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, shift register and counter; reset mid-word drops the remaining slices.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_IDLE;
            shift_r <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: an LSB-first and an MSB-first instance
// share one stimulus stream and are checked against hand-computed slices.
module tb_word_serializer;

    logic        clk_i;
    logic        reset_n_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_i;

    logic        ready_lsb_s, valid_lsb_s, last_lsb_s, busy_lsb_s;
    logic [7:0]  data_lsb_s;
    logic        ready_msb_s, valid_msb_s, last_msb_s, busy_msb_s;
    logic [7:0]  data_msb_s;

    int n_vec;
    int n_miss;

    word_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_lsb_s),
        .data_o(data_lsb_s), .valid_o(valid_lsb_s), .ready_i(ready_i),
        .last_o(last_lsb_s), .busy_o(busy_lsb_s)
    );

    word_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_msb_s),
        .data_o(data_msb_s), .valid_o(valid_msb_s), .ready_i(ready_i),
        .last_o(last_msb_s), .busy_o(busy_msb_s)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_vec({tag, "_valid"}, 32'(valid_lsb_s), 32'd0);
        check_vec({tag, "_last"},  32'(last_lsb_s),  32'd0);
        check_vec({tag, "_busy"},  32'(busy_lsb_s),  32'd0);
        check_vec({tag, "_data"},  32'(data_lsb_s),  32'd0);
        check_vec({tag, "_ready"}, 32'(ready_lsb_s), 32'd1);
        check_vec({tag, "_msb_valid"}, 32'(valid_msb_s), 32'd0);
        check_vec({tag, "_msb_ready"}, 32'(ready_msb_s), 32'd1);
    endtask

    // exp_lsb/exp_msb list the expected slices in output order, first slice in bits [31:24].
    task automatic run_word(input string tag, input logic [31:0] word,
                            input logic [31:0] exp_lsb, input logic [31:0] exp_msb);
        data_i  = word;
        valid_i = 1'b1;
        ready_i = 1'b1;
        @(negedge clk_i);
        check_vec({tag, "_accept_ready"}, 32'(ready_lsb_s), 32'd1);
        tick();
        valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check_vec($sformatf("%s_lsb_data%0d", tag, k), 32'(data_lsb_s), 32'(exp_lsb[31 - 8*k -: 8]));
            check_vec($sformatf("%s_lsb_valid%0d", tag, k), 32'(valid_lsb_s), 32'd1);
            check_vec($sformatf("%s_lsb_busy%0d", tag, k), 32'(busy_lsb_s), 32'd1);
            check_vec($sformatf("%s_lsb_last%0d", tag, k), 32'(last_lsb_s), (k == 3) ? 32'd1 : 32'd0);
            check_vec($sformatf("%s_lsb_ready%0d", tag, k), 32'(ready_lsb_s), (k == 3) ? 32'd1 : 32'd0);
            check_vec($sformatf("%s_msb_data%0d", tag, k), 32'(data_msb_s), 32'(exp_msb[31 - 8*k -: 8]));
            check_vec($sformatf("%s_msb_last%0d", tag, k), 32'(last_msb_s), (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        @(negedge clk_i);
        check_idle({tag, "_done"});
        tick();
    endtask

    logic [31:0] b2b_exp;

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        reset_n_i = 1'b0;
        data_i    = 32'h0;
        valid_i   = 1'b0;
        ready_i   = 1'b1;

        // Reset state, during and after release
        @(negedge clk_i);
        check_idle("rst_hold");
        tick();
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check_idle("rst_rel");
        tick();

        // Single word, both slice orders
        run_word("single", 32'hA1B2C3D4, 32'hD4C3B2A1, 32'hA1B2C3D4);

        // Back-to-back words, second accepted on the final slice of the first
        b2b_exp = 32'h44332211;
        data_i  = 32'h11223344;
        valid_i = 1'b1;
        ready_i = 1'b1;
        tick();
        data_i = 32'h55667788;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) b2b_exp = 32'h88776655;
            @(negedge clk_i);
            check_vec($sformatf("b2b_data%0d", k), 32'(data_lsb_s), 32'(b2b_exp[31 - 8*(k%4) -: 8]));
            check_vec($sformatf("b2b_valid%0d", k), 32'(valid_lsb_s), 32'd1);
            check_vec($sformatf("b2b_last%0d", k), 32'(last_lsb_s), ((k % 4) == 3) ? 32'd1 : 32'd0);
            if (k < 4)
                check_vec($sformatf("b2b_ready%0d", k), 32'(ready_lsb_s), (k == 3) ? 32'd1 : 32'd0);
            else
                check_vec($sformatf("b2b_ready%0d", k), 32'(ready_lsb_s), (k == 7) ? 32'd1 : 32'd0);
            tick();
            if (k == 3) valid_i = 1'b0;
        end
        @(negedge clk_i);
        check_idle("b2b_done");
        tick();

        // Backpressure on slice C3 while a foreign word is offered and must be ignored
        data_i  = 32'hA1B2C3D4;
        valid_i = 1'b1;
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        @(negedge clk_i);
        check_vec("bp_d4", 32'(data_lsb_s), 32'hD4);
        tick();
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_vec($sformatf("bp_hold_data%0d", k), 32'(data_lsb_s), 32'hC3);
            check_vec($sformatf("bp_hold_valid%0d", k), 32'(valid_lsb_s), 32'd1);
            check_vec($sformatf("bp_hold_ready%0d", k), 32'(ready_lsb_s), 32'd0);
            check_vec($sformatf("bp_hold_last%0d", k), 32'(last_lsb_s), 32'd0);
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        check_vec("bp_c3", 32'(data_lsb_s), 32'hC3);
        tick();
        @(negedge clk_i);
        check_vec("bp_b2", 32'(data_lsb_s), 32'hB2);
        tick();
        @(negedge clk_i);
        check_vec("bp_a1", 32'(data_lsb_s), 32'hA1);
        check_vec("bp_a1_last", 32'(last_lsb_s), 32'd1);
        tick();
        @(negedge clk_i);
        check_idle("bp_done");
        tick();

        // Reset after two slices, then a fresh word
        data_i  = 32'hA1B2C3D4;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        @(negedge clk_i);
        check_vec("mid_pre_rst", 32'(data_lsb_s), 32'hB2);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_idle("mid_rst");
        tick();
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check_idle("mid_rel");
        tick();
        run_word("after_rst", 32'h0000BEEF, 32'hEFBE0000, 32'h0000BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
